// File: rtl/md_issue.sv
// Issue controller between the E stage and the multiply/divide unit.
// Optional MD_FAST_START_EN: launch md_start combinationally in the accept cycle (no ISSUE state).
module md_issue (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic [2:0]  req_op,
    input  logic [31:0] req_a,
    input  logic [31:0] req_b,
    output logic        req_ready,
    output logic        stall,
    input  logic        flush,
    output logic [31:0] rd_data,
    output logic        md_start,
    output logic [2:0]  md_opt,
    output logic [31:0] md_v1,
    output logic [31:0] md_v2,
    input  logic        md_busy,
    input  logic [31:0] md_hi,
    input  logic [31:0] md_lo
);

`ifdef MD_FAST_START_EN
    typedef enum logic {IDLE, WAIT} state_t;
`else
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
`endif

    state_t      state, state_next;
    logic        start_op;
    logic        accept;
    logic        start_acc;
    logic [2:0]  opt_q;
    logic [31:0] v1_q, v2_q;

    assign start_op  = (req_op[2:1] != 2'b11);
    // Accept is held off during reset so nothing is taken while the MD unit is also resetting.
    assign accept    = req_valid & ~flush & ~reset &
                       ((state == IDLE) | ((state == WAIT) & ~md_busy));
    assign start_acc = accept & start_op;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
`ifdef MD_FAST_START_EN
                if (start_acc) state_next = WAIT;
`else
                if (start_acc) state_next = ISSUE;
`endif
            end
`ifndef MD_FAST_START_EN
            ISSUE: begin
                state_next = flush ? IDLE : WAIT;
            end
`endif
            WAIT: begin
                if (!md_busy) begin
`ifdef MD_FAST_START_EN
                    state_next = start_acc ? WAIT : IDLE;
`else
                    state_next = start_acc ? ISSUE : IDLE;
`endif
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            opt_q <= '0;
            v1_q  <= '0;
            v2_q  <= '0;
        end else if (start_acc) begin
            opt_q <= req_op;
            v1_q  <= req_a;
            v2_q  <= req_b;
        end
    end

    always_comb begin
        req_ready = accept;
        stall     = req_valid & ~accept;
        rd_data   = '0;
        if (accept && !start_op) begin
            rd_data = req_op[0] ? md_lo : md_hi;
        end
`ifdef MD_FAST_START_EN
        md_start = start_acc;
        md_opt   = start_acc ? req_op : opt_q;
        md_v1    = start_acc ? req_a  : v1_q;
        md_v2    = start_acc ? req_b  : v2_q;
`else
        md_start = (state == ISSUE) & ~flush & ~reset;
        md_opt   = opt_q;
        md_v1    = v1_q;
        md_v2    = v2_q;
`endif
    end

endmodule
